nco_phase_accumulator: RTL

Numerically controlled oscillator core for the synchronous IQ demodulator. Consumes the corrected 32-bit phase increment produced by the phase-increment correction stage and accumulates phase every enabled cycle. Emits signed cosine/sine reference samples from a quarter-wave ROM for the I and Q mixers. The block is fully pipelined and has a fixed latency.

---
 rtl/nco_pkg.sv | 56 +++++
 rtl/nco_quarter_sine_rom.sv | 37 +++
 rtl/nco_phase_accumulator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared constants, quadrant encoding and elaboration-time helpers for the NCO.
// Holds the default widths, the dither LFSR polynomial/seed and the quarter-wave ROM generator.
package nco_pkg;

  localparam int NCO_PHASE_W = 32;
  localparam int NCO_LUT_AW  = 10;
  localparam int NCO_AMP_W   = 16;

  // Right-shifting Galois form of x^32 + x^30 + x^26 + x^25 + 1 (maximal length).
  localparam logic [31:0] NCO_LFSR_TAPS = 32'hA300_0000;
  localparam logic [31:0] NCO_LFSR_SEED = 32'hACE1_2468;

  // pi scaled by 2^30, used by the integer sine generator below.
  localparam longint NCO_PI_Q30 = 64'sd3373259426;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } nco_quad_e;

  // Odd quadrants read the quarter wave backwards, the lower half-plane is negated.
  function automatic logic nco_mirror(input nco_quad_e q);
    return (q == Q1) || (q == Q3);
  endfunction

  function automatic logic nco_negate(input nco_quad_e q);
    return (q == Q2) || (q == Q3);
  endfunction

  function automatic logic [31:0] nco_lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? NCO_LFSR_TAPS : 32'h0);
  endfunction

  // round((2^(amp_w-1)-1) * sin(pi*(k+0.5)/2^(aw+1))) in Q30 fixed point, Taylor series to x^15.
  function automatic longint nco_quarter_sine(input int k, input int aw, input int amp_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scale;
    x     = (NCO_PI_Q30 * longint'(2 * k + 1) + (64'sd1 <<< (aw + 1))) / (64'sd1 <<< (aw + 2));
    x2    = (x * x) / (64'sd1 <<< 30);
    term  = x;
    sum   = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x2) / (64'sd1 <<< 30);
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scale = (64'sd1 <<< (amp_w - 1)) - 64'sd1;
    return (sum * scale + (64'sd1 <<< 29)) / (64'sd1 <<< 30);
  endfunction

endpackage

// File: rtl/nco_quarter_sine_rom.sv
// Dual-read quarter-wave sine ROM with registered outputs; contents are built at elaboration.
// Entries sit on half-sample centres so the table mirrors exactly and never holds zero.
module nco_quarter_sine_rom
  import nco_pkg::*;
#(
  parameter int AW = NCO_LUT_AW,
  parameter int DW = NCO_AMP_W - 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rd_en_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] data_a_o,
  output logic [DW-1:0] data_b_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] rom_w [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [DW-1:0] ENTRY = DW'(nco_quarter_sine(k, AW, DW + 1));
    assign rom_w[k] = ENTRY;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_a_o <= '0;
      data_b_o <= '0;
    end else if (rd_en_i) begin
      data_a_o <= rom_w[addr_a_i];
      data_b_o <= rom_w[addr_b_i];
    end
  end

endmodule

// File: rtl/nco_phase_accumulator.sv
// NCO core: phase accumulator, quarter-wave fold and signed cos/sin with a fixed 3-cycle latency.
// Optional truncation dither is enabled by defining NCO_DITHER_EN.
module nco_phase_accumulator
  import nco_pkg::*;
#(
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int LUT_AW  = NCO_LUT_AW,
  parameter int AMP_W   = NCO_AMP_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic                    phase_inc_load,
  input  logic [PHASE_W-1:0]      phase_offset,
  input  logic                    sync_clr,
  output logic signed [AMP_W-1:0] cos_out,
  output logic signed [AMP_W-1:0] sin_out,
  output logic                    out_valid,
  output logic                    wrap
);

  // en is a valid-only strobe with no back-pressure: every cycle it is high issues exactly one
  // sample, which appears three cycles later with out_valid; out_valid has no ready partner.

  localparam int DROP  = PHASE_W - 2 - LUT_AW;
  localparam int TOP_W = LUT_AW + 2;

  logic [PHASE_W-1:0] inc_q;
  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] acc_d;
  logic               carry_q;
  logic               carry_d;
  logic [PHASE_W-1:0] base_w;
  logic               sample_wrap_w;
  logic [TOP_W-1:0]   top_w;

  // carry_q is the carry that produced the current acc_q, so it travels with the sample using it.
  assign base_w        = sync_clr ? '0 : acc_q;
  assign sample_wrap_w = ~sync_clr & carry_q;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (sync_clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (en) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inc_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      if (phase_inc_load) begin
        inc_q <= phase_inc;
      end
    end
  end

`ifdef NCO_DITHER_EN
  logic [31:0] lfsr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_q <= NCO_LFSR_SEED;
    end else if (en) begin
      lfsr_q <= nco_lfsr_step(lfsr_q);
    end
  end

  assign top_w = TOP_W'((base_w + phase_offset + PHASE_W'(lfsr_q[DROP-1:0])) >> DROP);
`else
  assign top_w = TOP_W'((base_w + phase_offset) >> DROP);
`endif

  // Stage 1: quadrant and quarter-wave address.
  logic              v1_q;
  logic              w1_q;
  nco_quad_e         quad1_q;
  logic [LUT_AW-1:0] addr1_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q    <= 1'b0;
      w1_q    <= 1'b0;
      quad1_q <= Q0;
      addr1_q <= '0;
    end else begin
      v1_q <= en;
      w1_q <= en & sample_wrap_w;
      if (en) begin
        quad1_q <= nco_quad_e'(top_w[TOP_W-1 -: 2]);
        addr1_q <= top_w[LUT_AW-1:0];
      end
    end
  end

  nco_quad_e         cos_quad_w;
  logic [LUT_AW-1:0] sin_addr_w;
  logic [LUT_AW-1:0] cos_addr_w;

  assign cos_quad_w = nco_quad_e'(quad1_q + 2'd1);
  assign sin_addr_w = nco_mirror(quad1_q)    ? ~addr1_q : addr1_q;
  assign cos_addr_w = nco_mirror(cos_quad_w) ? ~addr1_q : addr1_q;

  // Stage 2: ROM read, sign decisions carried alongside.
  logic [AMP_W-2:0] sin_mag_w;
  logic [AMP_W-2:0] cos_mag_w;
  logic             v2_q;
  logic             w2_q;
  logic             sin_neg2_q;
  logic             cos_neg2_q;

  nco_quarter_sine_rom #(
    .AW(LUT_AW),
    .DW(AMP_W - 1)
  ) u_rom (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en_i  (v1_q),
    .addr_a_i (sin_addr_w),
    .addr_b_i (cos_addr_w),
    .data_a_o (sin_mag_w),
    .data_b_o (cos_mag_w)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2_q       <= 1'b0;
      w2_q       <= 1'b0;
      sin_neg2_q <= 1'b0;
      cos_neg2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      w2_q <= w1_q;
      if (v1_q) begin
        sin_neg2_q <= nco_negate(quad1_q);
        cos_neg2_q <= nco_negate(cos_quad_w);
      end
    end
  end

  // Stage 3: apply sign; magnitude tops out at 2^(AMP_W-1)-1 so negation cannot overflow.
  logic signed [AMP_W-1:0] sin_ext_w;
  logic signed [AMP_W-1:0] cos_ext_w;

  assign sin_ext_w = {1'b0, sin_mag_w};
  assign cos_ext_w = {1'b0, cos_mag_w};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      out_valid <= v2_q;
      wrap      <= w2_q;
      if (v2_q) begin
        sin_out <= sin_neg2_q ? -sin_ext_w : sin_ext_w;
        cos_out <= cos_neg2_q ? -cos_ext_w : cos_ext_w;
      end
    end
  end

endmodule
